uart_frame_decoder: RTL

- Upstream stage of the diff-freq serial-out engine; sits between the UART receiver and the pattern/frequency loader.
- Collects PACK_NUM bytes from the UART RX byte stream and assembles them into one command frame: output pattern, frequency pattern and control byte.
- Validates the frame and presents it to the downstream engine over a valid/ready handshake.
- Discards partial frames on inter-byte timeout and reports framing errors.

---
 rtl/uart_frame_decoder.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: collects PACK_NUM received UART bytes into one command
// frame (output pattern, frequency pattern, control byte), validates the
// control byte and presents the frame downstream over a valid/ready handshake.
// Partial frames are dropped on inter-byte timeout; errors are reported as a
// one-cycle strobe plus a sticky error code.
module uart_frame_decoder #(
    parameter int DATA_BIT    = 32,
    parameter int PACK_NUM    = 9,
    parameter int TIMEOUT_CLK = 10420
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          i_data,
    input  logic                i_rx_done_tick,
    input  logic                i_ready,
    output logic                o_valid,
    output logic [DATA_BIT-1:0] o_out_pattern,
    output logic [DATA_BIT-1:0] o_freq_pattern,
    output logic [3:0]          o_channel,
    output logic                o_mode,
    output logic [1:0]          o_cmd,
    output logic                o_err,
    output logic [1:0]          o_err_code,
    output logic [3:0]          o_byte_cnt
);

    localparam int              NB       = DATA_BIT / 8;
    localparam int              TW       = $clog2(TIMEOUT_CLK);
    localparam logic [3:0]      LAST_IDX = 4'(PACK_NUM - 1);
    localparam logic [TW-1:0]   TMO_MAX  = TW'(TIMEOUT_CLK - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        CHECK,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_TIMEOUT  = 2'b01,
        ERR_BAD_CTRL = 2'b10,
        ERR_OVERRUN  = 2'b11
    } err_code_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [7:0]     frame_q [PACK_NUM];

    logic           wr_en;
    logic [3:0]     wr_idx;
    logic           load_fields;
    logic           err_d;
    err_code_t      err_code_d;

    logic [7:0]          ctrl;
    logic                ctrl_ok;
    logic [DATA_BIT-1:0] out_asm;
    logic [DATA_BIT-1:0] freq_asm;

    // Control byte: [7:4] channel, [3] reserved (0), [2] mode, [1:0] cmd.
    assign ctrl    = frame_q[PACK_NUM-1];
    assign ctrl_ok = !ctrl[3] && (ctrl[1:0] == 2'b01 || ctrl[1:0] == 2'b10);

    assign o_valid    = (state_q == HOLD);
    assign o_byte_cnt = cnt_q;

    // Assemble both patterns from the buffer, lowest byte received first.
    always_comb begin
        out_asm  = '0;
        freq_asm = '0;
        for (int i = 0; i < NB; i++) begin
            out_asm[i*8 +: 8]  = frame_q[i];
            freq_asm[i*8 +: 8] = frame_q[NB + i];
        end
    end

    // Next-state, byte-store, timeout and error decisions.
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = '0;
        wr_en       = 1'b0;
        wr_idx      = cnt_q;
        load_fields = 1'b0;
        err_d       = 1'b0;
        err_code_d  = ERR_NONE;

        case (state_q)
            IDLE: begin
                if (i_rx_done_tick) begin
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    cnt_d   = 4'd1;
                    state_d = COLLECT;
                end
            end

            COLLECT: begin
                if (i_rx_done_tick) begin
                    // A tick always beats a coincident timeout.
                    wr_en  = 1'b1;
                    wr_idx = cnt_q;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = CHECK;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    cnt_d      = '0;
                    state_d    = IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            CHECK: begin
                if (ctrl_ok) begin
                    load_fields = 1'b1;
                    state_d     = HOLD;
                    if (i_rx_done_tick) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_OVERRUN;
                    end
                end else begin
                    // A rejected frame is the more important report; any
                    // coincident byte is dropped silently.
                    cnt_d      = '0;
                    state_d    = IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_BAD_CTRL;
                end
            end

            HOLD: begin
                if (i_ready) begin
                    if (i_rx_done_tick) begin
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        cnt_d   = 4'd1;
                        state_d = COLLECT;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (i_rx_done_tick) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OVERRUN;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, byte count and idle-timeout registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Byte buffer for the frame being collected.
    // NOTE: the buffer is deliberately not reset; every slot is rewritten before CHECK reads it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < PACK_NUM; i++) begin
                if (wr_idx == 4'(i)) begin
                    frame_q[i] <= i_data;
                end
            end
        end
    end

    // Field outputs: updated only when a frame passes the check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_out_pattern  <= '0;
            o_freq_pattern <= '0;
            o_channel      <= '0;
            o_mode         <= 1'b0;
            o_cmd          <= '0;
        end else if (load_fields) begin
            o_out_pattern  <= out_asm;
            o_freq_pattern <= freq_asm;
            o_channel      <= ctrl[7:4];
            o_mode         <= ctrl[2];
            o_cmd          <= ctrl[1:0];
        end
    end

    // Error strobe and sticky error code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_err      <= 1'b0;
            o_err_code <= '0;
        end else begin
            o_err <= err_d;
            if (err_d) begin
                o_err_code <= err_code_d;
            end
        end
    end

endmodule
